map_ss_seq: RTL and testbench
=============================

MAP_SS_SEQ -- requirements
Module: map_ss_seq

Interface
REQ-001 Parameter RD_LAT, default 2: clk cycles from ss_addr change to a valid ss_rdat sample.
REQ-002 Parameter WR_HOLD, default 4: clk cycles that ss_addr, ss_wdat and ss_we are held stable per restore write.
REQ-003 Parameter IDX_ADDR, default 8'd127: address of the read-only map index register.
REQ-004 clk  in  1  system clock, the only clock.
REQ-005 map_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start_save  in  1  single-cycle pulse; requests a snapshot.
REQ-007 start_load  in  1  single-cycle pulse; requests a restore.
REQ-008 last_reg  in  8  highest register index to transfer, sampled at start (below IDX_ADDR).
REQ-009 ss_act  out  1  save-state bus active.
REQ-010 ss_we  out  1  save-state write strobe.
REQ-011 ss_addr  out  8  register select.
REQ-012 ss_wdat  out  8  restore data, driven onto cpu_dat by the top level.
REQ-013 ss_rdat  in  8  mapper readback.
REQ-014 buf_addr  out  8  snapshot buffer address.
REQ-015 buf_we  out  1  buffer write strobe.
REQ-016 buf_wdat  out  8  buffer write data.
REQ-017 buf_rdat  in  8  buffer read data, valid 1 cycle after buf_addr.
REQ-018 busy  out  1  sequence in progress.
REQ-019 done  out  1  1-cycle pulse at sequence end.
REQ-020 err  out  1  sticky flag: map index mismatch on the last load.

Function
REQ-021 States SHALL be IDLE, S_ADDR, S_CAP, L_CHK0, L_CHK1, L_FETCH, L_WR, FIN.
REQ-022 In IDLE, start_save SHALL enter S_ADDR with idx=0 and start_load SHALL enter L_CHK0; if both pulse together, save SHALL win.
REQ-023 Starts arriving while busy SHALL be ignored, without queueing.
REQ-024 ss_act and busy SHALL be 1 in every state except IDLE.
REQ-025 S_ADDR: drive ss_addr=idx and wait RD_LAT cycles, then go to S_CAP.
REQ-026 S_CAP: buf_we=1, buf_addr=idx, buf_wdat=ss_rdat for exactly 1 cycle.
REQ-027 After S_CAP the sequencer SHALL advance idx as 0..last_reg, then IDX_ADDR, then FIN; the save sequence ends with entry IDX_ADDR captured.
REQ-028 L_CHK0: buf_addr=IDX_ADDR and ss_addr=IDX_ADDR for max(RD_LAT,1) cycles.
REQ-029 L_CHK1: compare buf_rdat with ss_rdat; on mismatch set err=1 and go to FIN with no ss_we issued; on match clear err, set idx=0 and go to L_FETCH.
REQ-030 L_FETCH: buf_addr=idx for 1 cycle; buf_rdat SHALL then be registered into ss_wdat.
REQ-031 L_WR: ss_addr=idx and ss_we=1 for WR_HOLD cycles, then ss_we=0 for 1 cycle with addr and data unchanged.
REQ-032 After L_WR, go to L_FETCH with idx+1, or to FIN when idx==last_reg.
REQ-033 ss_we SHALL never be 1 with ss_addr==IDX_ADDR.
REQ-034 FIN: done=1 for 1 cycle with ss_act still 1, then return to IDLE.
REQ-035 idx is 8 bits; last_reg=0 SHALL transfer exactly one register plus the index entry; last_reg>=IDX_ADDR SHALL be clamped to IDX_ADDR-1.
REQ-036 last_reg SHALL be latched at start; changes during a sequence have no effect.
REQ-037 ss_wdat, ss_addr and buf_addr SHALL change only while ss_we=0 and buf_we=0.

Reset
REQ-038 map_rst_n=0 SHALL asynchronously force IDLE and set ss_act, ss_we, buf_we, busy, done and err to 0, and ss_addr, ss_wdat, buf_addr, buf_wdat and idx to 0.
REQ-039 Reset mid-sequence SHALL abort immediately with no done pulse; the partially restored mapper state is accepted.

Structure
REQ-040 The state encoding and the IDX_ADDR default SHALL live in the shared defs package next to the ss_ctrl bus widths.
REQ-041 One sub-module, ss_hold_cnt, SHALL provide the shared wait counter for RD_LAT and WR_HOLD; all other logic SHALL be flat.

Verification
REQ-042 Save with last_reg=13 and mapper regs 0..13 = 0x10+i, idx=0xA5 -> buf[0..13]=0x10+i, buf[127]=0xA5, 15 buf_we pulses, one done.
REQ-043 Load with buf[127]=0xA5 matching live idx and buf[i]=0x40+i -> 14 writes, each with ss_we high exactly 4 cycles, in order 0..13, and err=0.
REQ-044 Load with buf[127]=0x3C and live idx 0xA5 -> zero ss_we pulses, err=1, done pulse.
REQ-045 start_save and start_load in the same cycle, then start_load again while busy -> only the save sequence runs.
REQ-046 map_rst_n asserted during the 3rd write of a load -> all outputs 0 in the same cycle, no done pulse.
REQ-047 last_reg=0, then last_reg=200 -> one register plus the index entry transferred, then clamped at 126.

Source files
------------

// File: rtl/map_ss_seq_pkg.sv
// Shared definitions for the save-state sequencer: bus widths, state encoding, index address.
// Helpers clamp the register range and floor wait lengths at one cycle.
package map_ss_seq_pkg;

  localparam int SS_AW = 8;
  localparam int SS_DW = 8;

  localparam logic [SS_AW-1:0] IDX_ADDR_DEF = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_CAP,
    L_CHK0,
    L_CHK1,
    L_FETCH,
    L_WR,
    FIN
  } seq_state_t;

  // The index entry is always transferred separately, so the data range stops just below it.
  function automatic logic [SS_AW-1:0] clamp_last(input logic [SS_AW-1:0] last,
                                                  input logic [SS_AW-1:0] idx_addr);
    return (last >= idx_addr) ? (idx_addr - SS_AW'(1)) : last;
  endfunction

  function automatic logic [7:0] at_least_one(input int n);
    return (n < 1) ? 8'd1 : 8'(n);
  endfunction

endpackage

// File: rtl/map_ss_seq_hold_cnt.sv
// Shared wait counter: counts cycles while run_i is high, hit_o flags the last cycle of len_i.
// Zero latency on hit_o; restarts from zero after a hit or whenever run_i drops.
module ss_hold_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [7:0] len_i,
  output logic [7:0] cnt_o,
  output logic       hit_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign hit_o = run_i && (cnt_q == (len_i - 8'd1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!run_i || hit_o) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/map_ss_seq.sv
// Save/restore sequencer moving mapper registers to a snapshot buffer and back, guarded by an index check.
// Read waits RD_LAT cycles per register, restore writes hold WR_HOLD cycles plus one release cycle.
module map_ss_seq
  import map_ss_seq_pkg::*;
#(
  parameter int               RD_LAT   = 2,
  parameter int               WR_HOLD  = 4,
  parameter logic [SS_AW-1:0] IDX_ADDR = IDX_ADDR_DEF
) (
  input  logic             clk,
  input  logic             map_rst_n,
  input  logic             start_save,
  input  logic             start_load,
  input  logic [SS_AW-1:0] last_reg,
  output logic             ss_act,
  output logic             ss_we,
  output logic [SS_AW-1:0] ss_addr,
  output logic [SS_DW-1:0] ss_wdat,
  input  logic [SS_DW-1:0] ss_rdat,
  output logic [SS_AW-1:0] buf_addr,
  output logic             buf_we,
  output logic [SS_DW-1:0] buf_wdat,
  input  logic [SS_DW-1:0] buf_rdat,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [7:0] RD_N = at_least_one(RD_LAT);
  localparam logic [7:0] WR_H = at_least_one(WR_HOLD);
  localparam logic [7:0] WR_N = WR_H + 8'd1;

  seq_state_t       state_q;
  logic [SS_AW-1:0] idx_q;
  logic [SS_AW-1:0] last_q;
  logic [SS_AW-1:0] ss_addr_q;
  logic [SS_DW-1:0] ss_wdat_q;
  logic             ss_we_q;
  logic [SS_AW-1:0] buf_addr_q;
  logic [SS_DW-1:0] buf_wdat_q;
  logic             err_q;

  logic             cnt_run;
  logic [7:0]       cnt_len;
  logic [7:0]       cnt_val;
  logic             cnt_hit;
  logic [SS_AW-1:0] idx_nxt;

  assign cnt_run = (state_q == S_ADDR) || (state_q == L_CHK0) || (state_q == L_WR);
  assign cnt_len = (state_q == L_WR) ? WR_N : RD_N;

  // Save walks the data range, then captures the index entry last.
  assign idx_nxt = (idx_q == last_q) ? IDX_ADDR : (idx_q + SS_AW'(1));

  ss_hold_cnt u_hold_cnt (
    .clk   (clk),
    .rst_n (map_rst_n),
    .run_i (cnt_run),
    .len_i (cnt_len),
    .cnt_o (cnt_val),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      ss_addr_q  <= '0;
      ss_wdat_q  <= '0;
      ss_we_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_wdat_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_save) begin
            state_q   <= S_ADDR;
            idx_q     <= '0;
            ss_addr_q <= '0;
            last_q    <= clamp_last(last_reg, IDX_ADDR);
          end else if (start_load) begin
            state_q    <= L_CHK0;
            ss_addr_q  <= IDX_ADDR;
            buf_addr_q <= IDX_ADDR;
            last_q     <= clamp_last(last_reg, IDX_ADDR);
          end
        end
        S_ADDR: begin
          if (cnt_hit) begin
            state_q    <= S_CAP;
            buf_addr_q <= idx_q;
            buf_wdat_q <= ss_rdat;
          end
        end
        S_CAP: begin
          if (idx_q == IDX_ADDR) begin
            state_q <= FIN;
          end else begin
            state_q   <= S_ADDR;
            idx_q     <= idx_nxt;
            ss_addr_q <= idx_nxt;
          end
        end
        L_CHK0: begin
          if (cnt_hit) begin
            state_q <= L_CHK1;
          end
        end
        L_CHK1: begin
          // A foreign snapshot must never reach the mapper.
          if (buf_rdat != ss_rdat) begin
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            err_q      <= 1'b0;
            idx_q      <= '0;
            buf_addr_q <= '0;
            state_q    <= L_FETCH;
          end
        end
        L_FETCH: begin
          ss_wdat_q <= buf_rdat;
          ss_addr_q <= idx_q;
          ss_we_q   <= 1'b1;
          state_q   <= L_WR;
        end
        L_WR: begin
          if (cnt_val == (WR_H - 8'd1)) begin
            ss_we_q <= 1'b0;
          end
          if (cnt_hit) begin
            ss_we_q <= 1'b0;
            if (idx_q == last_q) begin
              state_q <= FIN;
            end else begin
              idx_q      <= idx_q + SS_AW'(1);
              buf_addr_q <= idx_q + SS_AW'(1);
              state_q    <= L_FETCH;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign ss_act   = busy;
  assign done     = (state_q == FIN);
  assign buf_we   = (state_q == S_CAP);
  assign ss_we    = ss_we_q;
  assign ss_addr  = ss_addr_q;
  assign ss_wdat  = ss_wdat_q;
  assign buf_addr = buf_addr_q;
  assign buf_wdat = buf_wdat_q;
  assign err      = err_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: mapper model with one register of read delay, combinational snapshot buffer.
module tb_map_ss_seq;

  logic       clk = 1'b0;
  logic       map_rst_n;
  logic       start_save;
  logic       start_load;
  logic [7:0] last_reg;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdat;
  logic [7:0] buf_rdat;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  map_ss_seq dut (
    .clk        (clk),
    .map_rst_n  (map_rst_n),
    .start_save (start_save),
    .start_load (start_load),
    .last_reg   (last_reg),
    .ss_act     (ss_act),
    .ss_we      (ss_we),
    .ss_addr    (ss_addr),
    .ss_wdat    (ss_wdat),
    .ss_rdat    (ss_rdat),
    .buf_addr   (buf_addr),
    .buf_we     (buf_we),
    .buf_wdat   (buf_wdat),
    .buf_rdat   (buf_rdat),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Mapper: readback lands one register after the address, so a sample is good two edges later.
  logic [7:0] map_regs [256];
  logic [7:0] map_rdat_q;
  always @(posedge clk) map_rdat_q <= map_regs[ss_addr];
  assign ss_rdat = map_rdat_q;

  logic [7:0] buf_mem [256];
  logic       pl_we;
  logic [7:0] pl_addr;
  logic [7:0] pl_dat;
  always @(posedge clk) begin
    if (pl_we) buf_mem[pl_addr] <= pl_dat;
    else if (buf_we) buf_mem[buf_addr] <= buf_wdat;
  end
  assign buf_rdat = buf_mem[buf_addr];

  int         n_bufwe = 0;
  int         n_done = 0;
  int         n_idxwr = 0;
  int         n_unstable = 0;
  logic       we_prev = 1'b0;
  logic [7:0] cur_addr = 8'd0;
  logic [7:0] cur_dat = 8'd0;
  int         cur_hold = 0;
  logic [7:0] wr_addr [$];
  logic [7:0] wr_dat [$];
  int         wr_hold [$];

  always @(negedge clk) begin
    if (buf_we) n_bufwe++;
    if (done) n_done++;
    if (ss_we && ss_addr == 8'd127) n_idxwr++;
    if (ss_we) begin
      if (!we_prev) begin
        cur_addr = ss_addr;
        cur_dat  = ss_wdat;
        cur_hold = 0;
      end else if (ss_addr != cur_addr || ss_wdat != cur_dat) begin
        n_unstable++;
      end
      cur_hold++;
    end else if (we_prev) begin
      if (map_rst_n && (ss_addr != cur_addr || ss_wdat != cur_dat)) n_unstable++;
      wr_addr.push_back(cur_addr);
      wr_dat.push_back(cur_dat);
      wr_hold.push_back(cur_hold);
    end
    we_prev = ss_we;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic buf_put(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_dat  = d;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic l, input logic [7:0] last);
    start_save = s;
    start_load = l;
    last_reg   = last;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("seq_ends", busy, 0);
  endtask

  task automatic chk_write(input string tag, input int pos, input logic [7:0] a,
                           input logic [7:0] d);
    if (pos < wr_addr.size()) begin
      chk({tag, "_addr"}, wr_addr[pos], a);
      chk({tag, "_dat"}, wr_dat[pos], d);
      chk({tag, "_hold"}, wr_hold[pos], 4);
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  int b_we, b_done, b_wr, b_un, b_iw;

  task automatic snap();
    b_we   = n_bufwe;
    b_done = n_done;
    b_wr   = wr_addr.size();
    b_un   = n_unstable;
    b_iw   = n_idxwr;
  endtask

  initial begin
    map_rst_n  = 1'b0;
    start_save = 1'b0;
    start_load = 1'b0;
    last_reg   = 8'd0;
    pl_we      = 1'b0;
    pl_addr    = 8'd0;
    pl_dat     = 8'd0;
    for (int i = 0; i < 256; i++) map_regs[i] = 8'(i * 3 + 1);
    for (int i = 0; i < 14; i++) map_regs[i] = 8'(8'h10 + i);
    map_regs[127] = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {ss_act, ss_we, busy, done, err, buf_we}, 0);
    chk("rst_addr", {ss_addr, buf_addr}, 0);
    chk("rst_dat", {ss_wdat, buf_wdat}, 0);
    map_rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 21; i++) buf_put(8'(i), 8'h00);
    buf_put(8'd127, 8'h00);

    // Snapshot of 14 registers plus the index entry.
    snap();
    pulse(1'b1, 1'b0, 8'd13);
    chk("save_busy", {ss_act, busy}, 2'b11);
    wait_idle(2000);
    for (int i = 0; i < 14; i++) chk($sformatf("save_buf%0d", i), buf_mem[i], 32'h10 + i);
    chk("save_buf14_untouched", buf_mem[14], 0);
    chk("save_buf127", buf_mem[127], 8'hA5);
    chk("save_bufwe", n_bufwe - b_we, 15);
    chk("save_done", n_done - b_done, 1);

    // Restore with matching index.
    for (int i = 0; i < 14; i++) buf_put(8'(i), 8'(8'h40 + i));
    snap();
    pulse(1'b0, 1'b1, 8'd13);
    wait_idle(2000);
    chk("ld_nwr", wr_addr.size() - b_wr, 14);
    for (int i = 0; i < 14; i++) chk_write($sformatf("ld_wr%0d", i), b_wr + i, 8'(i), 8'(8'h40 + i));
    chk("ld_err", err, 0);
    chk("ld_done", n_done - b_done, 1);
    chk("ld_stable", n_unstable - b_un, 0);
    chk("ld_no_idx_wr", n_idxwr - b_iw, 0);

    // Restore with a foreign index: nothing written.
    buf_put(8'd127, 8'h3C);
    snap();
    pulse(1'b0, 1'b1, 8'd13);
    wait_idle(2000);
    chk("mis_nwr", wr_addr.size() - b_wr, 0);
    chk("mis_err", err, 1);
    chk("mis_done", n_done - b_done, 1);
    repeat (5) @(negedge clk);
    chk("mis_err_sticky", err, 1);

    // Simultaneous starts: save wins, later load while busy is dropped.
    snap();
    pulse(1'b1, 1'b1, 8'd2);
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1, 8'd2);
    wait_idle(2000);
    chk("both_bufwe", n_bufwe - b_we, 4);
    chk("both_nwr", wr_addr.size() - b_wr, 0);
    chk("both_done", n_done - b_done, 1);
    chk("both_err_kept", err, 1);
    repeat (20) @(negedge clk);
    chk("both_no_queue", busy, 0);
    chk("both_done_once", n_done - b_done, 1);

    // Reset during the third restore write.
    buf_put(8'd127, 8'hA5);
    snap();
    pulse(1'b0, 1'b1, 8'd13);
    begin
      int k = 0;
      while (!((wr_addr.size() - b_wr) == 2 && ss_we) && k < 1000) begin
        @(negedge clk);
        k++;
      end
      chk("rstmid_reach", (k < 1000), 1);
    end
    #2 map_rst_n = 1'b0;
    #1;
    chk("rstmid_ctl", {ss_act, ss_we, busy, done, err, buf_we}, 0);
    chk("rstmid_addr", {ss_addr, buf_addr}, 0);
    chk("rstmid_dat", {ss_wdat, buf_wdat}, 0);
    repeat (3) @(negedge clk);
    map_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_no_done", n_done - b_done, 0);
    chk("rstmid_idle", busy, 0);

    // Single register, with last_reg moving mid-sequence.
    snap();
    pulse(1'b1, 1'b0, 8'd0);
    last_reg = 8'd50;
    wait_idle(2000);
    chk("l0_save_bufwe", n_bufwe - b_we, 2);
    chk("l0_save_buf0", buf_mem[0], 8'h10);
    chk("l0_save_buf127", buf_mem[127], 8'hA5);
    snap();
    pulse(1'b0, 1'b1, 8'd0);
    last_reg = 8'd90;
    wait_idle(2000);
    chk("l0_ld_nwr", wr_addr.size() - b_wr, 1);
    chk_write("l0_ld_wr0", b_wr, 8'd0, 8'h10);
    chk("l0_ld_err", err, 0);

    // Oversized range clamps to 126.
    snap();
    pulse(1'b1, 1'b0, 8'd200);
    wait_idle(5000);
    chk("cl_save_bufwe", n_bufwe - b_we, 128);
    chk("cl_save_buf14", buf_mem[14], 8'h2B);
    chk("cl_save_buf50", buf_mem[50], 8'h97);
    chk("cl_save_buf126", buf_mem[126], 8'h7B);
    chk("cl_save_buf127", buf_mem[127], 8'hA5);
    snap();
    pulse(1'b0, 1'b1, 8'd200);
    wait_idle(5000);
    chk("cl_ld_nwr", wr_addr.size() - b_wr, 127);
    chk_write("cl_ld_first", b_wr, 8'd0, 8'h10);
    chk_write("cl_ld_last", b_wr + 126, 8'd126, 8'h7B);
    chk("cl_ld_no_idx_wr", n_idxwr - b_iw, 0);
    chk("cl_ld_stable", n_unstable - b_un, 0);
    chk("cl_ld_err", err, 0);
    chk("cl_ld_done", n_done - b_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
